// File: rtl/div_pkg.sv
// Shared types and default sizes for the sequential
// fixed-point divider.
package div_pkg;

  localparam int DEF_DW     = 24;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_OW     = DEF_DW + DEF_FRAC_W;
  localparam int DEF_CW     = $clog2(DEF_OW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One radix-2 restoring step: shift in a dividend bit,
// subtract the divisor when it fits.
module restoring_div_step #(
  parameter int DW = 24
) (
  input  logic [DW:0]   rem,
  input  logic          nbit,
  input  logic [DW-1:0] den,
  output logic [DW:0]   rem_next,
  output logic          qbit
);

  logic [DW:0] shifted;
  logic [DW:0] den_ext;

  assign shifted  = {rem[DW-1:0], nbit};
  assign den_ext  = {1'b0, den};
  assign qbit     = (shifted >= den_ext);
  assign rem_next = qbit ? (shifted - den_ext) : shifted;

endmodule

// File: rtl/axis_seq_divider.sv
// AXI-stream responder wrapping a bit-serial restoring
// divider producing floor((a << FRAC_W) / b).
module axis_seq_divider
  import div_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OW     = DW + FRAC_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] s_axis_dividend_tdata,
  input  logic          s_axis_dividend_tvalid,
  output logic          s_axis_dividend_tready,
  input  logic [DW-1:0] s_axis_divisor_tdata,
  input  logic          s_axis_divisor_tvalid,
  output logic          s_axis_divisor_tready,
  output logic [OW-1:0] m_axis_dout_tdata,
  output logic          m_axis_dout_tuser,
  output logic          m_axis_dout_tvalid,
  input  logic          m_axis_dout_tready
);

  localparam int CW = $clog2(OW);

  div_state_t    state;
  div_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [OW-1:0] num;
  logic [OW-1:0] quo;
  logic [DW:0]   rem;
  logic [DW-1:0] den;
  logic          dbz;
  logic [DW:0]   rem_next;
  logic          qbit;
  logic          accept;
  logic          last_step;
  logic          out_hs;

  restoring_div_step #(
    .DW(DW)
  ) u_step (
    .rem      (rem),
    .nbit     (num[OW-1]),
    .den      (den),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign last_step = (cnt == CW'(OW - 1));
  assign out_hs    = m_axis_dout_tvalid & m_axis_dout_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_hs)    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // The pair is only ever taken jointly; rstn gating keeps
  // both treadies low while reset is asserted.
  always_comb begin
    accept = rstn & (state == IDLE)
           & s_axis_dividend_tvalid
           & s_axis_divisor_tvalid;
    s_axis_dividend_tready = accept;
    s_axis_divisor_tready  = accept;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt                <= '0;
      num                <= '0;
      quo                <= '0;
      rem                <= '0;
      den                <= '0;
      dbz                <= 1'b0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tuser  <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            num <= OW'(s_axis_dividend_tdata) << FRAC_W;
            den <= s_axis_divisor_tdata;
            dbz <= (s_axis_divisor_tdata == '0);
            rem <= '0;
            quo <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          rem <= rem_next;
          num <= num << 1;
          quo <= {quo[OW-2:0], qbit};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (!m_axis_dout_tvalid) begin
            m_axis_dout_tvalid <= 1'b1;
            m_axis_dout_tdata  <= dbz ? '1 : quo;
            m_axis_dout_tuser  <= dbz;
          end else if (m_axis_dout_tready) begin
            m_axis_dout_tvalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_seq_divider.sv
// Directed vector bench for axis_seq_divider: results,
// latency, backpressure, partial valid and async reset.
module tb_axis_seq_divider;

  localparam int DW = 24;
  localparam int FW = 8;
  localparam int OW = 32;
  localparam int LAT = 33;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic [OW-1:0] q_data;
  logic          q_user;
  logic          q_valid;
  logic          q_ready;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] q;
    logic          u;
  } vec_t;

  vec_t vecs[8];

  axis_seq_divider dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .s_axis_dividend_tdata  (a_data),
    .s_axis_dividend_tvalid (a_valid),
    .s_axis_dividend_tready (a_ready),
    .s_axis_divisor_tdata   (b_data),
    .s_axis_divisor_tvalid  (b_valid),
    .s_axis_divisor_tready  (b_ready),
    .m_axis_dout_tdata      (q_data),
    .m_axis_dout_tuser      (q_user),
    .m_axis_dout_tvalid     (q_valid),
    .m_axis_dout_tready     (q_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic present(input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    a_data  = a;
    b_data  = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
  endtask

  // Waits for tvalid after the accept edge; checks latency
  // and payload.
  task automatic wait_result(input string name,
                             input logic [OW-1:0] eq,
                             input logic eu);
    int  lat;
    bit  got;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1 got = q_valid;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " tdata"}, 64'(q_data), 64'(eq));
    check({name, " tuser"}, 64'(q_user), 64'(eu));
  endtask

  task automatic run_pair(input string name,
                          input logic [DW-1:0] a,
                          input logic [DW-1:0] b,
                          input logic [OW-1:0] eq,
                          input logic eu);
    @(posedge clk);
    #1 present(a, b);
    @(negedge clk);
    check({name, " accept"}, 64'({a_ready, b_ready}), 64'(3));
    @(posedge clk);
    #1 a_valid = 1'b0;
    b_valid = 1'b0;
    wait_result(name, eq, eu);
    @(posedge clk);
    #1 check({name, " tvalid drop"}, 64'(q_valid), 64'(0));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    a_data  = '0;
    b_data  = '0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    q_ready = 1'b1;

    vecs[0] = '{24'd100, 24'd7, 32'h0000_0E49, 1'b0};
    vecs[1] = '{24'd0, 24'd5, 32'h0000_0000, 1'b0};
    vecs[2] = '{24'hFF_FFFF, 24'd1, 32'hFFFF_FF00, 1'b0};
    vecs[3] = '{24'd1234, 24'd0, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{24'd1, 24'd3, 32'h0000_0055, 1'b0};
    vecs[5] = '{24'hFF_FFFF, 24'hFF_FFFF, 32'h0000_0100, 1'b0};
    vecs[6] = '{24'h80_0000, 24'd3, 32'h2AAA_AAAA, 1'b0};
    vecs[7] = '{24'd7, 24'd100, 32'h0000_0011, 1'b0};

    repeat (2) @(negedge clk);
    check("reset tvalid", 64'(q_valid), 64'(0));
    check("reset tdata", 64'(q_data), 64'(0));
    check("reset tuser", 64'(q_user), 64'(0));
    check("reset treadies", 64'({a_ready, b_ready}), 64'(0));
    #1 rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_pair($sformatf("vec%0d", i), vecs[i].a,
               vecs[i].b, vecs[i].q, vecs[i].u);
    end

    // Backpressure with a new pair waiting.
    q_ready = 1'b0;
    @(posedge clk);
    #1 present(24'd100, 24'd7);
    @(posedge clk);
    #1 present(24'd5, 24'd2);
    wait_result("bp", 32'h0000_0E49, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold valid", 64'(q_valid), 64'(1));
      check("bp hold data", 64'(q_data), 64'h0E49);
      check("bp treadies", 64'({a_ready, b_ready}), 64'(0));
    end
    q_ready = 1'b1;
    @(posedge clk);
    #1 check("bp hs drop", 64'(q_valid), 64'(0));
    check("bp next ready", 64'({a_ready, b_ready}), 64'(3));
    @(posedge clk);
    #1 a_valid = 1'b0;
    b_valid = 1'b0;
    wait_result("bp next", 32'h0000_0280, 1'b0);

    // Only the dividend offered.
    @(posedge clk);
    #1 a_data = 24'd100;
    b_data = 24'd7;
    a_valid = 1'b1;
    b_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("half treadies", 64'({a_ready, b_ready}), 64'(0));
      check("half no out", 64'(q_valid), 64'(0));
    end
    b_valid = 1'b1;
    #1 check("half join ready", 64'({a_ready, b_ready}), 64'(3));
    @(posedge clk);
    #1 a_valid = 1'b0;
    b_valid = 1'b0;
    wait_result("half", 32'h0000_0E49, 1'b0);

    // Asynchronous reset in the middle of a division.
    @(posedge clk);
    #1 present(24'd1234, 24'd0);
    @(posedge clk);
    #1 a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("rst tvalid", 64'(q_valid), 64'(0));
    check("rst tdata", 64'(q_data), 64'(0));
    check("rst tuser", 64'(q_user), 64'(0));
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1 check("rst treadies", 64'({a_ready, b_ready}), 64'(0));
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    run_pair("post rst", 24'd100, 24'd7, 32'h0000_0E49, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
